tc_decoder_seq: RTL and testbench
=================================

# tc_decoder_seq

Registered, parametrised successor to the fixed 3-to-8 decoder. It holds a current index and drives it as a one-hot output vector of `OUT_N` lines. The index can be loaded directly, stepped up or down as a ring pointer, or fired as a single-cycle pulse. It sits in the component library as the select and strobe generator for register-file write enables, bus-source selects and round-robin pointers.

## Interface
Parameters:
- `OUT_N`, default 8: number of one-hot outputs; must be at least 2; need not be a power of two.
- `SEL_W`, derived localparam `$clog2(OUT_N)`: width of the select and index.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `dis`, in, 1: output disable; masks `out` and keeps internal state.
- `clear`, in, 1: deactivate the pointer.
- `load`, in, 1: load `sel` into the index and activate.
- `sel`, in, `SEL_W`: index to load.
- `step`, in, 1: advance the index by one position.
- `dir`, in, 1: step direction; 0 = up, 1 = down.
- `oneshot`, in, 1: when 1 at `load`, the output is a single-cycle pulse.
- `out`, out, `OUT_N`: registered one-hot output.
- `idx`, out, `SEL_W`: registered current index.
- `active`, out, 1: pointer is valid.
- `err`, out, 1: one-cycle flag for an out-of-range `load`.

## Operation
- Reset (`rst_n` = 0 at an edge): `idx` = 0, `active` = 0, `out` = 0, `err` = 0, pulse flag = 0.
- Command priority per edge: `clear` > `load` > `step`. Only one command takes effect per cycle.
- `clear`: `active` goes to 0 and `idx` is held.
- `load` with `sel` < `OUT_N`: `idx` takes `sel`, `active` goes to 1, and the pulse flag takes `oneshot`.
- `load` with `sel` >= `OUT_N`: the state is unchanged and `err` goes to 1 for one cycle. This includes an `active` pointer, which stays as it was.
- `step` while `active`:
  - `dir` = 0: `idx` goes to `idx`+1.
  - `dir` = 1: `idx` goes to `idx`−1.
  - End-of-range handling is set under Configuration.
- `step` while not `active`: ignored.
- Pulse flag set: `active` clears automatically at the edge after the first cycle in which `active` = 1.
  - A `step` in that same cycle is ignored.
  - A new `load` in that same cycle wins and restarts the pointer.
- `out` is `onehot(next idx)` when the next `active` = 1 and `dis` = 0 at the edge; otherwise `out` is all zeros.
- `dis` never changes `idx`, `active` or the pulse flag.
- Invariant: `out` has at most one bit set; no X values on `out` after reset.

## Timing
- All outputs are registered. Latency from a command to its visible effect is one cycle: a command sampled at edge t is visible on `out`, `idx` and `active` after edge t.
- `out`, `idx` and `active` update at the same edge, so `out` always matches `idx` and `active` from the same cycle, gated by the `dis` value sampled at that edge.
- Oneshot `load` at edge t: `out[sel]` is high for exactly one cycle (t to t+1). `active` is low after edge t+1.
- `err` is high for exactly the cycle after the offending edge.
- Reset mid-operation overrides every command at that edge.

## Configuration
- `TC_DECODER_SEQ_WRAP_EN` defined: `step` wraps around the ring.
  - Up from `OUT_N`−1 goes to 0.
  - Down from 0 goes to `OUT_N`−1.
- Macro undefined: `step` saturates.
  - Up at `OUT_N`−1 holds.
  - Down at 0 holds.
  - No error flag is raised.
- Applies to non-power-of-two `OUT_N` in both modes. Wrap compares against `OUT_N`−1, never relies on natural overflow of `SEL_W` bits.

## Structure
- Shared package `tc_decoder_pkg` holds:
  - the pure function `onehot(idx, n)`;
  - the direction constants `DIR_UP` = 0 and `DIR_DN` = 1.
- One sub-module `tc_decoder_comb`: combinational index-to-one-hot decode with a range-check output. It is reused for both the `out` decode and the `load` check.
- Top level holds the index register, active/pulse flags, priority logic and the output register.

## Test plan
- Reset then idle, `OUT_N` = 8: `out` = 0x00, `idx` = 0, `active` = 0, `err` = 0.
- `load` `sel` = 5, then 3 `step`s with `dir` = 0, wrap build: `out` = 0x20, 0x40, 0x80, 0x01. Same sequence, saturate build: 0x20, 0x40, 0x80, 0x80.
- `OUT_N` = 6, `load` `sel` = 0, `step` with `dir` = 1, wrap build: `idx` = 5, `out` = 6'b100000.
- `OUT_N` = 6, `load` `sel` = 7 while `idx` = 2 and `active`: `err` high for one cycle; `idx` = 2 and `out` = 6'b000100 unchanged.
- Oneshot `load` `sel` = 2 with `step` asserted the following cycle: `out` = 0x04 for one cycle, then 0x00; `active` = 0; `idx` stays 2.
- `load` `sel` = 4 with `dis` = 1, then `dis` = 0: `out` = 0x00 with `active` = 1, then `out` = 0x10. `clear` together with `load` in the same cycle leaves `active` = 0.

Source files
------------

// File: rtl/tc_decoder_seq_pkg.sv
// ============================================================================
// Module      : tc_decoder_pkg (package)
// Description : Shared definitions for the registered one-hot decoder /
//               ring-pointer family: step-direction constants and the
//               index-to-one-hot helper function.
// Contents    : MAX_N  - widest one-hot vector the helper can produce
//               DIR_UP - step direction "up"   (idx + 1)
//               DIR_DN - step direction "down" (idx - 1)
//               onehot(idx, n) - one-hot of idx, all zeros if idx >= n
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tc_decoder_pkg;

    localparam int MAX_N = 64;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Out-of-range indices decode to all zeros, so callers can rely on
    // "at most one bit set" without a separate guard.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx,
                                                input int unsigned n);
        logic [MAX_N-1:0] v;
        v = '0;
        if ((idx < n) && (idx < MAX_N)) begin
            v = MAX_N'(1) << idx;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tc_decoder_seq_if.sv
// ============================================================================
// Module      : tc_decoder_seq_if (interface)
// Description : Command / status bundle of tc_decoder_seq.
// Ports       : dis, clear, load, sel, step, dir, oneshot  (commands)
//               out, idx, active, err                       (status)
// Modports    : master - command source (drives commands, reads status)
//               slave  - the decoder (reads commands, drives status)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tc_decoder_seq_if #(
    parameter int OUT_N = 8
) ();
    localparam int SEL_W = $clog2(OUT_N);

    logic             dis;
    logic             clear;
    logic             load;
    logic [SEL_W-1:0] sel;
    logic             step;
    logic             dir;
    logic             oneshot;
    logic [OUT_N-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             active;
    logic             err;

    modport master (
        output dis, clear, load, sel, step, dir, oneshot,
        input  out, idx, active, err
    );

    modport slave (
        input  dis, clear, load, sel, step, dir, oneshot,
        output out, idx, active, err
    );
endinterface

`default_nettype wire

// File: rtl/tc_decoder_comb.sv
// ============================================================================
// Module      : tc_decoder_comb
// Description : Combinational index-to-one-hot decode with range check.
//               Indices >= OUT_N decode to all zeros and in_range = 0.
// Ports       : idx        in  SEL_W  index to decode
//               onehot_out out OUT_N  one-hot of idx (zero if out of range)
//               in_range   out 1      idx < OUT_N
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_decoder_comb
    import tc_decoder_pkg::*;
#(
    parameter int OUT_N = 8,
    localparam int SEL_W = $clog2(OUT_N)
) (
    input  wire logic [SEL_W-1:0] idx,
    output logic      [OUT_N-1:0] onehot_out,
    output logic                  in_range
);
    // Compare in 32 bits: for non-power-of-two OUT_N the SEL_W-bit index
    // can hold values past the last line.
    assign in_range   = (32'(idx) < 32'(OUT_N));
    assign onehot_out = OUT_N'(onehot(32'(idx), 32'(OUT_N)));
endmodule

`default_nettype wire

// File: rtl/tc_decoder_seq.sv
// ============================================================================
// Module      : tc_decoder_seq
// Description : Registered, parametrised one-hot decoder / ring pointer.
//               Holds an index that can be loaded, stepped up/down, or fired
//               as a single-cycle pulse; drives it as a one-hot vector.
//               Command priority: clear > load > step.
// Ports       : clk    in  1  rising-edge clock
//               rst_n  in  1  synchronous active-low reset
//               bus    slave modport of tc_decoder_seq_if
// Config      : TC_DECODER_SEQ_WRAP_EN defined   -> step wraps on the ring
//               TC_DECODER_SEQ_WRAP_EN undefined -> step saturates at ends
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_decoder_seq
    import tc_decoder_pkg::*;
#(
    parameter int OUT_N = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    tc_decoder_seq_if.slave bus
);
    localparam int SEL_W = $clog2(OUT_N);
    localparam logic [SEL_W-1:0] c_last_idx = SEL_W'(OUT_N - 1);

    logic [SEL_W-1:0] r_idx;
    logic             r_active;
    logic             r_pulse;
    logic             r_err;
    logic [OUT_N-1:0] r_out;

    logic [SEL_W-1:0] w_nxt_idx;
    logic             w_nxt_active;
    logic             w_nxt_pulse;
    logic             w_nxt_err;
    logic [OUT_N-1:0] w_nxt_onehot;
    logic             w_nxt_in_range;
    logic [OUT_N-1:0] w_sel_onehot;
    logic             w_sel_in_range;
    logic             w_sel_ok;

    tc_decoder_comb #(.OUT_N(OUT_N)) u_sel_dec (
        .idx        (bus.sel),
        .onehot_out (w_sel_onehot),
        .in_range   (w_sel_in_range)
    );

    // Range flag and decoded vector agree by construction; requiring both
    // is a cheap cross-check on the load path.
    assign w_sel_ok = w_sel_in_range && (w_sel_onehot != '0);

    tc_decoder_comb #(.OUT_N(OUT_N)) u_out_dec (
        .idx        (w_nxt_idx),
        .onehot_out (w_nxt_onehot),
        .in_range   (w_nxt_in_range)
    );

    always_comb begin
        w_nxt_idx    = r_idx;
        w_nxt_active = r_active;
        w_nxt_pulse  = r_pulse;
        w_nxt_err    = 1'b0;
        if (bus.clear) begin
            w_nxt_active = 1'b0;
        end else if (bus.load) begin
            if (w_sel_ok) begin
                w_nxt_idx    = bus.sel;
                w_nxt_active = 1'b1;
                w_nxt_pulse  = bus.oneshot;
            end else begin
                // Bad select leaves every piece of state untouched.
                w_nxt_err = 1'b1;
            end
        end else if (r_active && r_pulse) begin
            // Pulse has had its single visible cycle; any step is dropped.
            w_nxt_active = 1'b0;
            w_nxt_pulse  = 1'b0;
        end else if (bus.step && r_active) begin
            if (bus.dir == DIR_UP) begin
                if (r_idx == c_last_idx) begin
`ifdef TC_DECODER_SEQ_WRAP_EN
                    w_nxt_idx = '0;
`else
                    w_nxt_idx = r_idx;
`endif
                end else begin
                    w_nxt_idx = r_idx + SEL_W'(1);
                end
            end else begin
                if (r_idx == '0) begin
`ifdef TC_DECODER_SEQ_WRAP_EN
                    w_nxt_idx = c_last_idx;
`else
                    w_nxt_idx = r_idx;
`endif
                end else begin
                    w_nxt_idx = r_idx - SEL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_active <= 1'b0;
            r_pulse  <= 1'b0;
            r_err    <= 1'b0;
            r_out    <= '0;
        end else begin
            r_idx    <= w_nxt_idx;
            r_active <= w_nxt_active;
            r_pulse  <= w_nxt_pulse;
            r_err    <= w_nxt_err;
            // Output tracks the next-state index so out/idx/active align.
            r_out    <= (w_nxt_active && !bus.dis && w_nxt_in_range)
                        ? w_nxt_onehot : '0;
        end
    end

    assign bus.out    = r_out;
    assign bus.idx    = r_idx;
    assign bus.active = r_active;
    assign bus.err    = r_err;
endmodule

`default_nettype wire

// File: tb/tb_tc_decoder_seq.sv
// ============================================================================
// Module      : tb_tc_decoder_seq
// Description : Scoreboard bench for tc_decoder_seq. Two instances run side
//               by side (OUT_N = 8 and OUT_N = 6). A reference model of the
//               pointer rules produces the expected status for every cycle
//               issued; a monitor pops and compares one cycle later.
// Config      : honours TC_DECODER_SEQ_WRAP_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tc_decoder_seq;

`ifdef TC_DECODER_SEQ_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        bit clr; bit ld; int sel; bit stp; bit dir; bit os; bit dis;
    } cmd_t;

    typedef struct {
        string           tag;
        int              idx;
        bit              act;
        bit              err;
        longint unsigned out;
    } exp_t;

    logic clk;
    logic rst_n;

    tc_decoder_seq_if #(.OUT_N(8)) bus_a ();
    tc_decoder_seq_if #(.OUT_N(6)) bus_b ();

    tc_decoder_seq #(.OUT_N(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    tc_decoder_seq #(.OUT_N(6)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    // Model state: index, pointer valid, pulse pending.
    int m_idx[2];
    bit m_act[2];
    bit m_pls[2];

    function automatic cmd_t mk(bit clr, bit ld, int sel, bit stp, bit dir,
                                bit os, bit dis);
        cmd_t c;
        c.clr = clr; c.ld = ld; c.sel = sel; c.stp = stp;
        c.dir = dir; c.os = os; c.dis = dis;
        return c;
    endfunction

    function automatic exp_t model(int d, cmd_t c, bit rst, int n, string tag);
        exp_t e;
        e.tag = tag;
        e.err = 1'b0;
        if (rst) begin
            m_idx[d] = 0; m_act[d] = 1'b0; m_pls[d] = 1'b0;
        end else if (c.clr) begin
            m_act[d] = 1'b0;
        end else if (c.ld) begin
            if (c.sel < n) begin
                m_idx[d] = c.sel; m_act[d] = 1'b1; m_pls[d] = c.os;
            end else begin
                e.err = 1'b1;
            end
        end else if (m_act[d] && m_pls[d]) begin
            m_act[d] = 1'b0; m_pls[d] = 1'b0;
        end else if (c.stp && m_act[d]) begin
            if (c.dir == 1'b0)
                m_idx[d] = (m_idx[d] + 1 < n) ? m_idx[d] + 1 : (WRAP ? 0 : n - 1);
            else
                m_idx[d] = (m_idx[d] > 0) ? m_idx[d] - 1 : (WRAP ? n - 1 : 0);
        end
        e.idx = m_idx[d];
        e.act = m_act[d];
        e.out = (m_act[d] && !c.dis && !rst) ? (64'd1 << m_idx[d]) : 64'd0;
        return e;
    endfunction

    task automatic cyc(input bit rst, input cmd_t ca, input cmd_t cb,
                       input string tag);
        int sa;
        int sb;
        sa = ca.sel; sb = cb.sel;
        rst_n         = !rst;
        bus_a.clear   = ca.clr; bus_a.load = ca.ld;  bus_a.sel = sa[2:0];
        bus_a.step    = ca.stp; bus_a.dir  = ca.dir; bus_a.oneshot = ca.os;
        bus_a.dis     = ca.dis;
        bus_b.clear   = cb.clr; bus_b.load = cb.ld;  bus_b.sel = sb[2:0];
        bus_b.step    = cb.stp; bus_b.dir  = cb.dir; bus_b.oneshot = cb.os;
        bus_b.dis     = cb.dis;
        q_a.push_back(model(0, ca, rst, 8, tag));
        q_b.push_back(model(1, cb, rst, 6, tag));
        @(posedge clk);
        #2;
    endtask

    task automatic cmp(input string name, input longint unsigned act,
                       input longint unsigned req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic check(input string who, input exp_t e, input int idx_v,
                         input bit act_v, input bit err_v,
                         input longint unsigned out_v);
        cmp({who, " ", e.tag, " idx"},    64'(idx_v), 64'(e.idx));
        cmp({who, " ", e.tag, " active"}, 64'(act_v), 64'(e.act));
        cmp({who, " ", e.tag, " err"},    64'(err_v), 64'(e.err));
        cmp({who, " ", e.tag, " out"},    out_v,      e.out);
        cmp({who, " ", e.tag, " onehot"}, 64'($countones(out_v) <= 1), 64'd1);
    endtask

    // Monitor: the decoder presents fresh status every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("N8", e, int'(bus_a.idx), bus_a.active, bus_a.err,
                      64'(bus_a.out));
            end
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("N6", e, int'(bus_b.idx), bus_b.active, bus_b.err,
                      64'(bus_b.out));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t idle;
        cmd_t ra;
        cmd_t rb;
        idle = mk(0, 0, 0, 0, 0, 0, 0);

        cyc(1, idle, idle, "reset");
        cyc(1, idle, idle, "reset");
        cyc(0, idle, idle, "idle");

        // Load 5 then step up three times (wrap vs saturate at 7).
        cyc(0, mk(0, 1, 5, 0, 0, 0, 0), idle, "load5");
        for (int i = 0; i < 3; i++)
            cyc(0, mk(0, 0, 0, 1, 0, 0, 0), idle, "stepup");

        // OUT_N = 6: step down from 0.
        cyc(0, idle, mk(0, 1, 0, 0, 0, 0, 0), "load0");
        cyc(0, idle, mk(0, 0, 0, 1, 1, 0, 0), "stepdn0");

        // OUT_N = 6: out-of-range load while active at 2.
        cyc(0, idle, mk(0, 1, 2, 0, 0, 0, 0), "load2");
        cyc(0, idle, mk(0, 1, 7, 0, 0, 0, 0), "load7");
        cyc(0, idle, idle, "afterbad");

        // Oneshot load with a step the following cycle.
        cyc(0, mk(0, 1, 2, 0, 0, 1, 0), idle, "oneshot");
        cyc(0, mk(0, 0, 0, 1, 0, 0, 0), idle, "osstep");
        cyc(0, idle, idle, "osidle");

        // Disable masks output only; clear beats load.
        cyc(0, mk(0, 1, 4, 0, 0, 0, 1), idle, "loaddis");
        cyc(0, idle, idle, "undis");
        cyc(0, mk(1, 1, 3, 0, 0, 0, 0), idle, "clrload");
        cyc(0, idle, idle, "postclr");

        for (int i = 0; i < 1500; i++) begin
            ra = mk($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) == 0);
            rb = mk($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) == 0);
            cyc($urandom_range(0, 99) == 0, ra, rb, "rand");
        end

        cyc(0, idle, idle, "tail");
        @(posedge clk);
        #3;
        cmp("drain N8", 64'(q_a.size()), 64'd0);
        cmp("drain N6", 64'(q_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
